pipelined_add_sub: RTL and testbench
====================================

Name: pipelined_add_sub

Overview:
- Parametrised, pipelined adder/subtractor with a per-stage registered carry chain.
- Operands are split into STAGES slices of WIDTH/STAGES bits; each slice is added in its own pipeline stage.
- Successor to the team's combinational ripple adder/subtractor. Adds valid/ready flow control, signed/unsigned flags and optional saturation.
- Sits in datapath accumulators and address-offset units where long carry chains break timing.

Parameters:
- WIDTH, 16: operand and result width in bits.
- STAGES, 4: pipeline depth, which is also the slice count. Legal when 1 <= STAGES <= WIDTH and WIDTH % STAGES == 0; otherwise elaboration fails.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  pipeline accepts a beat this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- sub  input  1  0: A+B; 1: A-B (B inverted, carry-in = 1)
- signed_mode  input  1  1: two's-complement interpretation for flags/saturation
- sat_en  input  1  1: clamp result on overflow
- out_valid  output  1  result beat valid
- out_ready  input  1  downstream accepts the result
- result  output  WIDTH  sum/difference, saturated if requested
- carry_out  output  1  raw carry out of the MSB (for sub: 1 = no borrow)
- overflow  output  1  add: unsigned carry; sub: borrow (signed_mode=0); signed overflow (signed_mode=1); reported before saturation
- zero  output  1  result == 0 (post-saturation)

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits cleared; result, carry_out, overflow, zero and out_valid = 0. in_ready = 1 once reset deasserts.
- Accept: a beat is captured when in_valid && in_ready. sub, signed_mode and sat_en are captured with the beat and travel with it.
- Stall: stall = out_valid && !out_ready.
  - in_ready = !stall.
  - While stalled, every stage register holds; there are no bubbles-collapse requirements.
- Advance: when not stalled, every stage shifts one step and stage 0 loads the new beat, or a bubble if there is no valid beat.
- Latency: exactly STAGES cycles from accept to out_valid when not stalled. Throughput is one beat per cycle.
- Stage k (k = 0..STAGES-1):
  - Adds slice k of A and of (B ^ {WIDTH{sub}}) with the carry registered from stage k-1. Stage 0 uses sub as carry-in.
  - Unprocessed upper slices are delayed alongside the beat; completed lower sum slices are delayed to the output.
- Final stage flags:
  - carry_out = carry from MSB.
  - Signed overflow = (A[MSB] == Bx[MSB]) && (sum[MSB] != A[MSB]), where Bx is B after optional inversion.
  - Unsigned overflow = carry_out ^ sub.
- Saturation (sat_en=1 and overflow=1):
  - signed: result = 0x7FF..F if A[MSB]=0, else 0x800..0.
  - unsigned: add -> all ones; sub -> 0.
  - With sat_en=0, result wraps modulo 2^WIDTH.
- Outputs: result and flags are registered and stable while out_valid && !out_ready.
- Simultaneous in_valid and out_ready with a full pipe: the output pops and the input is accepted in the same cycle. in_ready is 1 because stall = 0.
- Reset mid-operation: all in-flight beats are discarded; no partial result is emitted after reset.
- STAGES=1: a single registered full-width add, latency 1.

Test Plan:
1. WIDTH=16, STAGES=4, out_ready=1. a=0x1234, b=0x0FFF, add -> result 0x2233 four cycles after accept; carry_out=0, overflow=0, zero=0.
2. Carry across every slice: a=0xFFFF, b=0x0001, add, unsigned. With sat_en=0 -> result 0x0000, carry_out=1, overflow=1, zero=1. With sat_en=1 -> result 0xFFFF.
3. Signed saturation:
   - a=0x7FFF, b=0x0001, add, signed_mode=1, sat_en=1 -> result 0x7FFF, overflow=1.
   - a=0x8000, b=0x0001, sub -> result 0x8000, overflow=1.
   - Unsigned sub: a=0x0003, b=0x0005, sat_en=1, signed_mode=0 -> result 0x0000, carry_out=0, overflow=1.
4. Back-to-back streaming: 8 consecutive beats (a=i, b=2i, alternating sub) -> 8 consecutive out_valid cycles in order. Results are 3i for add and (-i mod 2^16) for sub.
5. Backpressure: fill the pipe, then hold out_ready=0 for 5 cycles -> in_ready=0, result held constant and no beat lost or duplicated. Release -> remaining beats drain in order, one per cycle.
6. Reset: assert rst_n=0 with 3 beats in flight -> out_valid and result go to 0 immediately (asynchronous). After release, no stale beat appears; a new beat has latency 4.

Source files
------------

// File: rtl/pipelined_add_sub.sv
// pipelined_add_sub
//   Pipelined adder/subtractor. The operands are cut into STAGES slices of
//   WIDTH/STAGES bits. Stage k adds slice k and registers the slice carry for
//   stage k+1. The final stage also produces the flags and applies saturation,
//   and its registers drive the outputs directly. Latency is exactly STAGES
//   cycles. Throughput is one beat per cycle.
//
//   Handshake: a beat transfers on a port in any cycle where valid && ready
//   are both high at the rising clock edge. The producer holds its data stable
//   until that cycle. The pipeline is a single lock-step shift register:
//   stall = out_valid && !out_ready freezes every stage, and in_ready = !stall.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   input beat handshake
//   a, b                  operands (WIDTH bits)
//   sub                   0: a+b, 1: a-b
//   signed_mode           two's-complement interpretation for overflow/saturation
//   sat_en                clamp the result when overflow is flagged
//   out_valid / out_ready result handshake
//   result                sum/difference, saturated when requested
//   carry_out             raw carry out of the MSB (for sub: 1 = no borrow)
//   overflow              unsigned carry/borrow or signed overflow, before saturation
//   zero                  result == 0 (after saturation)
module pipelined_add_sub #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             signed_mode,
  input  logic             sat_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  generate
    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
      $error("pipelined_add_sub: STAGES must divide WIDTH and lie in 1..WIDTH");
    end
  endgenerate

  localparam int SW   = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  // Per-stage registers. Entry k holds the beat after slice k was added:
  // the untouched operands (upper slices still pending), the partial sum
  // and the carry into slice k+1.
  logic [WIDTH-1:0]  st_a   [STAGES];
  logic [WIDTH-1:0]  st_bx  [STAGES];
  logic [WIDTH-1:0]  st_sum [STAGES];
  logic [STAGES-1:0] st_c, st_v, st_sub, st_sgn, st_sat;

  logic [WIDTH-1:0]  nxt_a   [STAGES];
  logic [WIDTH-1:0]  nxt_bx  [STAGES];
  logic [WIDTH-1:0]  nxt_sum [STAGES];
  logic [STAGES-1:0] nxt_c, nxt_v, nxt_sub, nxt_sgn, nxt_sat;

  logic [WIDTH-1:0] cur_a, cur_bx, cur_sum;
  logic             cur_c, cur_v, cur_sub, cur_sgn, cur_sat;
  logic [SW:0]      slice;

  logic             stall;
  logic [WIDTH-1:0] fin_sum, fin_res, smax, smin;
  logic             fin_c, fin_amsb, fin_bmsb, fin_ov;

  assign out_valid = st_v[LAST];
  assign stall     = out_valid && !out_ready;
  assign in_ready  = !stall;

  // Slice adders. "cur" is whatever feeds stage k: the input port for k=0,
  // otherwise the register of stage k-1.
  always_comb begin
    nxt_c   = '0;
    nxt_v   = '0;
    nxt_sub = '0;
    nxt_sgn = '0;
    nxt_sat = '0;
    slice   = '0;
    cur_a   = a;
    cur_bx  = b ^ {WIDTH{sub}};
    cur_sum = '0;
    cur_c   = sub;
    cur_v   = in_valid;
    cur_sub = sub;
    cur_sgn = signed_mode;
    cur_sat = sat_en;
    for (int k = 0; k < STAGES; k++) begin
      slice = {1'b0, cur_a[k*SW +: SW]} + {1'b0, cur_bx[k*SW +: SW]} + {{SW{1'b0}}, cur_c};
      nxt_sum[k]             = cur_sum;
      nxt_sum[k][k*SW +: SW] = slice[SW-1:0];
      nxt_c[k]               = slice[SW];
      nxt_a[k]               = cur_a;
      nxt_bx[k]              = cur_bx;
      nxt_v[k]               = cur_v;
      nxt_sub[k]             = cur_sub;
      nxt_sgn[k]             = cur_sgn;
      nxt_sat[k]             = cur_sat;
      cur_a   = st_a[k];
      cur_bx  = st_bx[k];
      cur_sum = st_sum[k];
      cur_c   = st_c[k];
      cur_v   = st_v[k];
      cur_sub = st_sub[k];
      cur_sgn = st_sgn[k];
      cur_sat = st_sat[k];
    end
  end

  // Flags and saturation on the completed sum, ahead of the output registers.
  always_comb begin
    fin_sum  = nxt_sum[LAST];
    fin_c    = nxt_c[LAST];
    fin_amsb = nxt_a[LAST][WIDTH-1];
    fin_bmsb = nxt_bx[LAST][WIDTH-1];
    // Bx is already inverted for sub, so the add-overflow rule covers both ops.
    if (nxt_sgn[LAST]) fin_ov = (fin_amsb == fin_bmsb) && (fin_sum[WIDTH-1] != fin_amsb);
    else               fin_ov = fin_c ^ nxt_sub[LAST];
    smax = '1;
    smax[WIDTH-1] = 1'b0;
    smin = '0;
    smin[WIDTH-1] = 1'b1;
    fin_res = fin_sum;
    if (nxt_sat[LAST] && fin_ov) begin
      if (nxt_sgn[LAST]) fin_res = fin_amsb ? smin : smax;
      else               fin_res = nxt_sub[LAST] ? '0 : '1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_c      <= '0;
      st_v      <= '0;
      st_sub    <= '0;
      st_sgn    <= '0;
      st_sat    <= '0;
      for (int k = 0; k < STAGES; k++) begin
        st_a[k]   <= '0;
        st_bx[k]  <= '0;
        st_sum[k] <= '0;
      end
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else if (!stall) begin
      st_c   <= nxt_c;
      st_v   <= nxt_v;
      st_sub <= nxt_sub;
      st_sgn <= nxt_sgn;
      st_sat <= nxt_sat;
      for (int k = 0; k < STAGES; k++) begin
        st_a[k]   <= nxt_a[k];
        st_bx[k]  <= nxt_bx[k];
        st_sum[k] <= nxt_sum[k];
      end
      // Bubbles leave the last visible result in place.
      if (nxt_v[LAST]) begin
        result    <= fin_res;
        carry_out <= fin_c;
        overflow  <= fin_ov;
        zero      <= (fin_res == '0);
      end
    end
  end

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Testbench for pipelined_add_sub (WIDTH=16, STAGES=4). The bench drives
// directed and random beats. A reference model computes the expected value
// of each beat from integer arithmetic when the beat is accepted. A
// scoreboard compares the outputs in order and also checks latency.
module tb_pipelined_add_sub;
  localparam int W = 16;
  localparam int S = 4;

  logic         clk, rst_n;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] a, b, result;
  logic         sub, signed_mode, sat_en;
  logic         carry_out, overflow, zero;

  pipelined_add_sub #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .signed_mode(signed_mode), .sat_en(sat_en),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry_out(carry_out), .overflow(overflow), .zero(zero)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit lat_chk = 1'b0;
  bit rnd_done = 1'b0;

  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1, "watchdog");
  end

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Packed as {result, carry_out, overflow, zero}.
  function automatic logic [W+2:0] model(logic [W-1:0] x, logic [W-1:0] y,
                                         logic s, logic sg, logic st);
    int ux, uy, sx, sy, ur, sr;
    logic [W-1:0] r;
    logic c, ov;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    ur = s ? ux - uy : ux + uy;
    sr = s ? sx - sy : sx + sy;
    r  = W'(ur);
    c  = s ? (ux >= uy) : (ur > (1 << W) - 1);
    if (sg) ov = (sr > (1 << (W-1)) - 1) || (sr < -(1 << (W-1)));
    else    ov = s ? (ux < uy) : (ur > (1 << W) - 1);
    if (st && ov) begin
      if (sg) r = (sr > 0) ? W'((1 << (W-1)) - 1) : W'(1 << (W-1));
      else    r = s ? '0 : '1;
    end
    return {r, c, ov, (r == '0)};
  endfunction

  // ---------------- scoreboard ----------------
  logic [W+2:0] exp_q[$];
  int           acc_q[$];

  // Sampled on the falling edge: handshakes seen here take effect at the next rising edge.
  always @(negedge clk) begin
    int a_c;
    if (rst_n) begin
      check("in_ready", {31'd0, in_ready}, {31'd0, !(out_valid && !out_ready)});
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 32'd1, 32'd0);
        end else begin
          check("result_flags", {13'd0, result, carry_out, overflow, zero}, {13'd0, exp_q[0]});
          if (out_ready) begin
            void'(exp_q.pop_front());
            a_c = acc_q.pop_front();
            if (lat_chk) check("latency", cyc - a_c, S);
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, sub, signed_mode, sat_en));
        acc_q.push_back(cyc);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(logic [W-1:0] x, logic [W-1:0] y,
                      logic s = 1'b0, logic sg = 1'b0, logic st = 1'b0);
    bit acc = 1'b0;
    in_valid = 1'b1;
    a = x; b = y; sub = s; signed_mode = sg; sat_en = st;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready && rst_n;
      @(posedge clk);
      #1;
    end
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return 16'h7FFF;
      3: return 16'h8000;
      default: return W'($urandom);
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; signed_mode = 1'b0; sat_en = 1'b0;
    out_ready = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", {16'd0, result}, 32'd0);
    check("rst_carry", {31'd0, carry_out}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_zero", {31'd0, zero}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Directed cases with latency checking.
    lat_chk = 1'b1;
    send(16'h1234, 16'h0FFF);
    idle(6);
    send(16'hFFFF, 16'h0001);
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
    idle(6);
    send(16'h7FFF, 16'h0001, 1'b0, 1'b1, 1'b1);
    send(16'h8000, 16'h0001, 1'b1, 1'b1, 1'b1);
    send(16'h0003, 16'h0005, 1'b1, 1'b0, 1'b1);
    idle(6);

    // Back-to-back streaming, alternating add/sub.
    for (int i = 0; i < 8; i++) send(W'(i), W'(2 * i), i[0]);
    idle(6);

    // Backpressure: the pipe fills behind a stalled output.
    lat_chk = 1'b0;
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) send(rnd_op(), rnd_op(), 1'($urandom_range(0, 1)));
        idle(1);
      end
      begin
        repeat (10) begin
          @(posedge clk);
          #1;
        end
        check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        check("bp_out_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
      end
    join
    idle(8);
    check("bp_drained", exp_q.size(), 32'd0);

    // Reset with three beats still in flight.
    lat_chk = 1'b1;
    for (int i = 1; i <= 5; i++) send(W'(16'h0111 * i), W'(16'h0101 * i));
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_result", {16'd0, result}, 32'd0);
    check("midrst_zero", {31'd0, zero}, 32'd0);
    exp_q.delete();
    acc_q.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    idle(8);
    send(16'h0101, 16'h0202);
    idle(6);

    // Random traffic with random backpressure.
    lat_chk = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          send(rnd_op(), rnd_op(), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        in_valid = 1'b0;
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    idle(12);
    check("final_queue_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
